// File: rtl/boot_selector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_selector_pkg : FSM state encoding and default timer tap bits    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package boot_selector_pkg;

   typedef enum logic [2:0] {
      ST_START    = 3'd0,
      ST_WAIT     = 3'd1,
      ST_SEL      = 3'd2,
      ST_SEL_WAIT = 3'd3,
      ST_COMMIT   = 3'd4,
      ST_LOCK     = 3'd5,
      ST_BOOT     = 3'd6
   } state_t;

   localparam int TMR_W_DEF      = 24;
   localparam int SEL_TO_BIT_DEF = 23;
   localparam int REARM_BIT_DEF  = 17;
   localparam int LONG_BIT_DEF   = 22;
   localparam int FL_TO_BIT_DEF  = 20;

endpackage
`default_nettype wire

// File: rtl/boot_selector_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_selector_timer : state-dwell timer and button hold counter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module boot_selector_timer
   import boot_selector_pkg::*;
#(
   parameter int TMR_W      = TMR_W_DEF,
   parameter int SEL_TO_BIT = SEL_TO_BIT_DEF,
   parameter int REARM_BIT  = REARM_BIT_DEF,
   parameter int LONG_BIT   = LONG_BIT_DEF,
   parameter int FL_TO_BIT  = FL_TO_BIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_v,
   input  logic state_chg,
   output logic sel_to_tick,
   output logic rearm_tick,
   output logic fl_to_tick,
   output logic long_press
);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic [TMR_W-1:0] hold_q, hold_d;

   // The timer measures released time in the current state only, so a
   // held button keeps it parked at zero.
   always_comb begin
      timer_d = timer_q + TMR_W'(1);
      if (state_chg || !btn_v) begin
         timer_d = '0;
      end
   end

   always_comb begin
      hold_d = '0;
      if (!btn_v) begin
         hold_d = hold_q[LONG_BIT] ? hold_q : hold_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign sel_to_tick = timer_q[SEL_TO_BIT];
   assign rearm_tick  = timer_q[REARM_BIT];
   assign fl_to_tick  = timer_q[FL_TO_BIT];
   assign long_press  = hold_q[LONG_BIT];

endmodule
`default_nettype wire

// File: rtl/boot_selector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_selector : button-driven warm-boot image selector with lock     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module boot_selector
   import boot_selector_pkg::*;
#(
   parameter int SEL_W       = 2,
   parameter int SEL_MIN     = 0,
   parameter int SEL_MAX     = 3,
   parameter int DEFAULT_IMG = 2,
   parameter int DFU_IMG     = 1,
   parameter int TMR_W       = TMR_W_DEF,
   parameter int SEL_TO_BIT  = SEL_TO_BIT_DEF,
   parameter int REARM_BIT   = REARM_BIT_DEF,
   parameter int LONG_BIT    = LONG_BIT_DEF,
   parameter int FL_TO_BIT   = FL_TO_BIT_DEF,
   parameter logic [2**SEL_W-1:0] LOCK_MASK = 4'b1110
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_v,
   input  logic             btn_f,
   input  logic             fl_rdy,
   output logic             fl_go,
   output logic             fl_err,
   output logic             sel_active,
   output logic [SEL_W-1:0] boot_sel,
   output logic             boot_now
);

   localparam logic [SEL_W-1:0] SEL_MIN_V     = SEL_W'(SEL_MIN);
   localparam logic [SEL_W-1:0] SEL_MAX_V     = SEL_W'(SEL_MAX);
   localparam logic [SEL_W-1:0] DEFAULT_IMG_V = SEL_W'(DEFAULT_IMG);
   localparam logic [SEL_W-1:0] DFU_IMG_V     = SEL_W'(DFU_IMG);

   if (!(SEL_MIN <= DFU_IMG && DFU_IMG <= SEL_MAX && SEL_MAX < 2**SEL_W
         && DEFAULT_IMG < 2**SEL_W)) begin : g_chk_sel
      $error("boot_selector: image range parameters inconsistent");
   end

   if (SEL_TO_BIT >= TMR_W || REARM_BIT >= TMR_W || LONG_BIT >= TMR_W
       || FL_TO_BIT >= TMR_W) begin : g_chk_bits
      $error("boot_selector: timer tap bit outside TMR_W");
   end

   state_t           state_q, state_d;
   logic [SEL_W-1:0] boot_sel_q, boot_sel_d;
   logic             boot_now_q, boot_now_d;
   logic             fl_err_q, fl_err_d;
   logic             sel_to_tick, rearm_tick, fl_to_tick, long_press;

   function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] x);
      return (x == SEL_MAX_V) ? SEL_MIN_V : x + SEL_W'(1);
   endfunction

   boot_selector_timer #(
      .TMR_W      (TMR_W),
      .SEL_TO_BIT (SEL_TO_BIT),
      .REARM_BIT  (REARM_BIT),
      .LONG_BIT   (LONG_BIT),
      .FL_TO_BIT  (FL_TO_BIT)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_v       (btn_v),
      .state_chg   (state_d != state_q),
      .sel_to_tick (sel_to_tick),
      .rearm_tick  (rearm_tick),
      .fl_to_tick  (fl_to_tick),
      .long_press  (long_press)
   );

   always_comb begin
      state_d    = state_q;
      boot_sel_d = boot_sel_q;
      boot_now_d = boot_now_q;
      fl_err_d   = fl_err_q;
      fl_go      = 1'b0;
      case (state_q)
         ST_START: begin
            if (btn_v) begin
               state_d = ST_COMMIT;
            end else begin
               boot_sel_d = DFU_IMG_V;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (btn_v) state_d = ST_SEL_WAIT;
         end
         // A press landing on the timeout cycle still advances the image.
         ST_SEL: begin
            if (btn_f) begin
               boot_sel_d = sel_inc(boot_sel_q);
               state_d    = ST_SEL_WAIT;
            end else if (sel_to_tick) begin
               state_d = ST_COMMIT;
            end
         end
         ST_SEL_WAIT: begin
            if (long_press)      state_d = ST_COMMIT;
            else if (rearm_tick) state_d = ST_SEL;
         end
         ST_COMMIT: begin
            if (LOCK_MASK[boot_sel_q]) begin
               fl_go   = 1'b1;
               state_d = ST_LOCK;
            end else begin
               state_d = ST_BOOT;
            end
         end
         ST_LOCK: begin
            if (fl_rdy) begin
               state_d = ST_BOOT;
            end else if (fl_to_tick) begin
               fl_err_d = 1'b1;
               state_d  = ST_BOOT;
            end
         end
         ST_BOOT: begin
            boot_now_d = 1'b1;
         end
         default: begin
            state_d = ST_START;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_START;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) boot_sel_q <= DEFAULT_IMG_V;
      else        boot_sel_q <= boot_sel_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) boot_now_q <= 1'b0;
      else        boot_now_q <= boot_now_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fl_err_q <= 1'b0;
      else        fl_err_q <= fl_err_d;
   end

   assign sel_active = (state_q == ST_WAIT) || (state_q == ST_SEL)
                       || (state_q == ST_SEL_WAIT);
   assign boot_sel   = boot_sel_q;
   assign boot_now   = boot_now_q;
   assign fl_err     = fl_err_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_selector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_boot_selector : vector table, directed corners and random runs    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_boot_selector;

   localparam int SEL_MIN     = 0;
   localparam int SEL_MAX     = 3;
   localparam int DEFAULT_IMG = 2;
   localparam int DFU_IMG     = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_v = 1'b1;
   logic       btn_f = 1'b0;
   logic       fl_rdy = 1'b0;
   logic       fl_go, fl_err, sel_active, boot_now;
   logic [1:0] boot_sel;

   int n_cmp = 0;
   int n_bad = 0;
   int rdy_delay = -1;
   int rdy_cnt = -1;
   int go_cnt = 0;
   logic [3:0] lock_mask = 4'b1110;

   typedef struct {
      bit         held;
      int         n_press;
      bit         long_fin;
      int         d;
      logic [1:0] exp_sel;
      bit         exp_go;
      bit         exp_err;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   boot_selector #(
      .SEL_W(2), .SEL_MIN(SEL_MIN), .SEL_MAX(SEL_MAX),
      .DEFAULT_IMG(DEFAULT_IMG), .DFU_IMG(DFU_IMG),
      .TMR_W(8), .SEL_TO_BIT(7), .REARM_BIT(3), .LONG_BIT(6), .FL_TO_BIT(5),
      .LOCK_MASK(4'b1110)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_v(btn_v), .btn_f(btn_f), .fl_rdy(fl_rdy),
      .fl_go(fl_go), .fl_err(fl_err), .sel_active(sel_active),
      .boot_sel(boot_sel), .boot_now(boot_now)
   );

   // Flash-lock responder: raises fl_rdy rdy_delay cycles after fl_go.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         fl_rdy  = 1'b0;
         rdy_cnt = -1;
         go_cnt  = 0;
      end else begin
         if (fl_go) begin
            go_cnt++;
            rdy_cnt = rdy_delay;
         end else if (rdy_cnt > 0) begin
            rdy_cnt--;
         end
         if (rdy_cnt == 0) fl_rdy = 1'b1;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset(input logic btn_level);
      @(negedge clk);
      rst_n = 1'b0;
      btn_v = btn_level;
      btn_f = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic press(input int hold_cycles);
      btn_v = 1'b0;
      btn_f = 1'b1;
      cyc(1);
      btn_f = 1'b0;
      cyc(hold_cycles - 1);
      btn_v = 1'b1;
   endtask

   task automatic wait_boot();
      int waited = 0;
      while (boot_now !== 1'b1 && waited < 400) begin
         cyc(1);
         waited++;
      end
   endtask

   // Image chosen from the rules: default when not held, else DFU image
   // advanced once per press (a long press is also a press), wrapping.
   function automatic logic [1:0] model_sel(input bit held, input int n, input bit lng);
      int span = SEL_MAX - SEL_MIN + 1;
      if (!held) return 2'(DEFAULT_IMG);
      return 2'(SEL_MIN + (DFU_IMG - SEL_MIN + n + int'(lng)) % span);
   endfunction

   task automatic run_scenario(input string tag, input vec_t v);
      rdy_delay = v.d;
      apply_reset(v.held ? 1'b0 : 1'b1);
      if (v.held) begin
         cyc(3);
         check({tag, " sel_active"}, 32'(sel_active), 32'd1);
         cyc(2);
         btn_v = 1'b1;
      end
      for (int i = 0; i < v.n_press; i++) begin
         cyc(20);
         press(4);
      end
      if (v.long_fin) begin
         cyc(20);
         press(80);
      end
      wait_boot();
      check({tag, " boot_now"}, 32'(boot_now), 32'd1);
      check({tag, " boot_sel"}, 32'(boot_sel), 32'(v.exp_sel));
      check({tag, " fl_err"},   32'(fl_err),   32'(v.exp_err));
      check({tag, " fl_go count"}, 32'(go_cnt), 32'(v.exp_go));
      cyc(2);
      press(4);
      cyc(5);
      check({tag, " frozen boot_sel"}, 32'(boot_sel), 32'(v.exp_sel));
      check({tag, " held boot_now"},   32'(boot_now), 32'd1);
   endtask

   initial begin
      logic [1:0] seq_exp[4];
      vec_t rv;

      vecs[0] = '{held:0, n_press:0, long_fin:0, d:4,  exp_sel:2'd2, exp_go:1, exp_err:0};
      vecs[1] = '{held:1, n_press:0, long_fin:0, d:4,  exp_sel:2'd1, exp_go:1, exp_err:0};
      vecs[2] = '{held:1, n_press:4, long_fin:0, d:6,  exp_sel:2'd1, exp_go:1, exp_err:0};
      vecs[3] = '{held:1, n_press:1, long_fin:0, d:-1, exp_sel:2'd2, exp_go:1, exp_err:1};
      vecs[4] = '{held:1, n_press:3, long_fin:0, d:-1, exp_sel:2'd0, exp_go:0, exp_err:0};
      vecs[5] = '{held:1, n_press:0, long_fin:1, d:-1, exp_sel:2'd2, exp_go:1, exp_err:1};
      vecs[6] = '{held:1, n_press:5, long_fin:0, d:3,  exp_sel:2'd2, exp_go:1, exp_err:0};
      seq_exp = '{2'd2, 2'd3, 2'd0, 2'd1};

      // Reset values
      rdy_delay = 4;
      rst_n = 1'b0;
      btn_v = 1'b1;
      #12;
      check("reset boot_sel", 32'(boot_sel), 32'd2);
      check("reset boot_now", 32'(boot_now), 32'd0);
      check("reset fl_go", 32'(fl_go), 32'd0);
      check("reset fl_err", 32'(fl_err), 32'd0);
      check("reset sel_active", 32'(sel_active), 32'd0);

      // Released at power-up: straight to COMMIT with a single fl_go pulse
      apply_reset(1'b1);
      cyc(1);
      check("direct fl_go pulse", 32'(fl_go), 32'd1);
      cyc(1);
      check("direct fl_go low", 32'(fl_go), 32'd0);
      wait_boot();
      check("direct boot_now", 32'(boot_now), 32'd1);
      check("direct boot_sel", 32'(boot_sel), 32'd2);

      for (int i = 0; i < 7; i++) begin
         run_scenario($sformatf("vec%0d", i), vecs[i]);
      end

      // Spaced presses walk the image list with wrap
      rdy_delay = 4;
      apply_reset(1'b0);
      cyc(5);
      btn_v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(20);
         press(4);
         check($sformatf("press_seq step%0d", i), 32'(boot_sel), 32'(seq_exp[i]));
      end
      wait_boot();
      check("press_seq final", 32'(boot_sel), 32'd1);

      // Long press commits while the button is still down
      rdy_delay = 4;
      apply_reset(1'b0);
      cyc(5);
      btn_v = 1'b1;
      cyc(20);
      btn_v = 1'b0;
      btn_f = 1'b1;
      cyc(1);
      btn_f = 1'b0;
      cyc(69);
      check("long sel_active", 32'(sel_active), 32'd0);
      check("long boot_sel", 32'(boot_sel), 32'd2);
      check("long fl_go count", 32'(go_cnt), 32'd1);
      btn_v = 1'b1;
      wait_boot();
      check("long boot_now", 32'(boot_now), 32'd1);

      // Asynchronous reset while in LOCK
      rdy_delay = -1;
      apply_reset(1'b1);
      cyc(10);
      check("lockrst pre fl_err", 32'(fl_err), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("lockrst boot_sel", 32'(boot_sel), 32'd2);
      check("lockrst boot_now", 32'(boot_now), 32'd0);
      check("lockrst fl_go", 32'(fl_go), 32'd0);
      check("lockrst fl_err", 32'(fl_err), 32'd0);
      btn_v = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      check("lockrst restart sel_active", 32'(sel_active), 32'd1);
      check("lockrst restart boot_sel", 32'(boot_sel), 32'd1);
      btn_v = 1'b1;

      // Random scenarios against the rule-level model
      for (int k = 0; k < 12; k++) begin
         rv.held     = ($urandom_range(0, 3) != 0);
         rv.n_press  = int'($urandom_range(0, 6));
         rv.long_fin = $urandom_range(0, 1) == 1;
         rv.d        = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 28));
         rv.exp_sel  = model_sel(rv.held, rv.n_press, rv.long_fin);
         rv.exp_go   = lock_mask[rv.exp_sel];
         rv.exp_err  = rv.exp_go && (rv.d < 0 || rv.d > 33);
         run_scenario($sformatf("rand%0d", k), rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
